// File: rtl/scs8hd_o2bb2a_pkg.sv
// Shared constants and helpers for the pipelined o2bb2a lane-qualifier block.
// Holds the MODE encodings, the popcount helper and the popcount width function.
package scs8hd_o2bb2a_pkg;

    localparam logic MODE_TRUE = 1'b0;
    localparam logic MODE_INV  = 1'b1;

    // One extra bit of headroom, so a count of LANES ones never wraps.
    function automatic int calc_cw(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/scs8hd_o2bb2a_pipe_stage.sv
// One valid/ready register slice. Ready propagates combinationally upstream
// so a full chain can still accept and emit on the same edge.
module scs8hd_o2bb2a_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            // Payload only moves with a real beat; bubbles leave it untouched.
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/scs8hd_o2bb2a_pipe.sv
// Multi-lane o2bb2a: X_i = (!(A1N&A2N) & |B_lane) ^ MODE, with popcount,
// carried through a STAGES-deep valid/ready register pipeline.
module scs8hd_o2bb2a_pipe
    import scs8hd_o2bb2a_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int NB     = 2,
    parameter int STAGES = 2,
    localparam int CW    = calc_cw(LANES)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [LANES-1:0]    A1N,
    input  logic [LANES-1:0]    A2N,
    input  logic [LANES*NB-1:0] B,
    input  logic                MODE,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [LANES-1:0]    X,
    output logic [CW-1:0]       OUT_ONES
`ifdef SC_USE_PG_PIN
    ,
    input  logic                vpwr,
    input  logic                vgnd,
    input  logic                vpb,
    input  logic                vnb
`endif
);

    localparam int PW = LANES + CW;

    logic [LANES-1:0] w_r;
    logic [LANES-1:0] w_x;
    logic [CW-1:0]    w_ones;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_r[gi] = !(A1N[gi] & A2N[gi]) & (|B[gi*NB +: NB]);
        end
    endgenerate

    assign w_x    = (MODE == MODE_INV) ? ~w_r : w_r;
    assign w_ones = CW'(popcount(32'(w_x)));

    logic          w_valid [0:STAGES];
    logic          w_ready [0:STAGES];
    logic [PW-1:0] w_data  [0:STAGES];

    assign w_valid[0]      = IN_VALID;
    assign w_data[0]       = {w_ones, w_x};
    assign w_ready[STAGES] = OUT_READY;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            scs8hd_o2bb2a_pipe_stage #(
                .W(PW)
            ) u_stage (
                .clk    (CLK),
                .srst   (RESET),
                .i_valid(w_valid[gi]),
                .o_ready(w_ready[gi]),
                .i_data (w_data[gi]),
                .o_valid(w_valid[gi+1]),
                .i_ready(w_ready[gi+1]),
                .o_data (w_data[gi+1])
            );
        end
    endgenerate

    assign IN_READY  = w_ready[0] & !RESET;
    assign OUT_VALID = w_valid[STAGES];

    logic [PW-1:0] w_head;
    assign w_head = w_data[STAGES];

`ifdef SC_USE_PG_PIN
    // Bad supply corrupts the data outputs; handshake is left alone.
    logic w_pg_ok;
    assign w_pg_ok  = (vpwr == 1'b1) && (vgnd == 1'b0);
    assign X        = w_pg_ok ? w_head[LANES-1:0] : 'x;
    assign OUT_ONES = w_pg_ok ? w_head[PW-1:LANES] : 'x;
`else
    assign X        = w_head[LANES-1:0];
    assign OUT_ONES = w_head[PW-1:LANES];
`endif

endmodule

// File: tb/tb_scs8hd_o2bb2a_pipe.sv
// Scoreboard bench: three DUTs (STAGES 2, 4, 1) share stimulus; each has its own
// expected-beat queue filled on acceptance and drained by a monitor on output transfer.
module tb_scs8hd_o2bb2a_pipe;

    typedef struct packed {
        logic [7:0]  a1n;
        logic [7:0]  a2n;
        logic [15:0] b;
        logic        mode;
        logic [7:0]  x;
        logic [3:0]  ones;
    } vec_t;

    typedef struct packed {
        logic [7:0] x;
        logic [3:0] ones;
        int         cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        OUT_READY;
    logic [7:0]  A1N;
    logic [7:0]  A2N;
    logic [15:0] B;
    logic        MODE;

    logic       in_ready  [3];
    logic       out_valid [3];
    logic [7:0] x_o       [3];
    logic [3:0] ones_o    [3];

    vec_t tbl [10];
    exp_t sb_q [3][$];
    int   cur_idx = 0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int sd(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            scs8hd_o2bb2a_pipe #(
                .LANES (8),
                .NB    (2),
                .STAGES((gi == 0) ? 2 : ((gi == 1) ? 4 : 1))
            ) u_dut (
                .CLK      (CLK),
                .RESET    (RESET),
                .IN_VALID (IN_VALID),
                .IN_READY (in_ready[gi]),
                .A1N      (A1N),
                .A2N      (A2N),
                .B        (B),
                .MODE     (MODE),
                .OUT_VALID(out_valid[gi]),
                .OUT_READY(OUT_READY),
                .X        (x_o[gi]),
                .OUT_ONES (ones_o[gi])
            );
        end
    endgenerate

    // Push on acceptance, pop on output transfer; reset flushes in-flight expectations.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (RESET) begin
            for (int k = 0; k < 3; k++) sb_q[k].delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (IN_VALID && in_ready[k]) begin
                    e.x    = tbl[cur_idx].x;
                    e.ones = tbl[cur_idx].ones;
                    e.cyc  = cyc;
                    sb_q[k].push_back(e);
                end
                if (out_valid[k] && OUT_READY) begin
                    n_tests++;
                    if (sb_q[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL stale_beat dut%0d: got X=%0h ones=%0d, required no beat", k, x_o[k], ones_o[k]);
                    end else begin
                        e = sb_q[k].pop_front();
                        if (x_o[k] !== e.x || ones_o[k] !== e.ones) begin
                            n_fail++;
                            $display("FAIL beat_data dut%0d: got X=%0h ones=%0d, required X=%0h ones=%0d",
                                     k, x_o[k], ones_o[k], e.x, e.ones);
                        end
                        n_tests++;
                        if (cyc - e.cyc < sd(k)) begin
                            n_fail++;
                            $display("FAIL beat_latency dut%0d: got %0d cycles, required >= %0d", k, cyc - e.cyc, sd(k));
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic apply(input int idx);
        cur_idx = idx;
        A1N  = tbl[idx].a1n;
        A2N  = tbl[idx].a2n;
        B    = tbl[idx].b;
        MODE = tbl[idx].mode;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hold the beat until DUT0 takes it; returns just after the accepting edge.
    task automatic send(input int idx);
        bit done;
        done = 1'b0;
        apply(idx);
        IN_VALID = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge CLK);
            done = in_ready[0];
            tick();
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no acceptance of beat %0d, required acceptance within 64 cycles", idx);
        end
    endtask

    initial begin
        logic [7:0] x_hold;
        logic [3:0] ones_hold;

        // a1n, a2n, b, mode -> hand-computed x, ones (8 lanes, NB=2)
        tbl[0] = '{8'hF3, 8'hF5, 16'h0024, 1'b0, 8'h06, 4'd2};
        tbl[1] = '{8'hF3, 8'hF5, 16'h0024, 1'b1, 8'hF9, 4'd6};
        tbl[2] = '{8'h00, 8'h00, 16'hFFFF, 1'b0, 8'hFF, 4'd8};
        tbl[3] = '{8'h00, 8'h00, 16'hFFFF, 1'b1, 8'h00, 4'd0};
        tbl[4] = '{8'hFF, 8'hFF, 16'hFFFF, 1'b0, 8'h00, 4'd0};
        tbl[5] = '{8'hFF, 8'hFF, 16'hFFFF, 1'b1, 8'hFF, 4'd8};
        tbl[6] = '{8'hAA, 8'hCC, 16'h5555, 1'b0, 8'h77, 4'd6};
        tbl[7] = '{8'h0F, 8'hFF, 16'hC003, 1'b0, 8'h80, 4'd1};
        tbl[8] = '{8'h0F, 8'hFF, 16'hC003, 1'b1, 8'h7F, 4'd7};
        tbl[9] = '{8'h00, 8'hFF, 16'h2A2A, 1'b1, 8'h88, 4'd2};

        // Reset with IN_VALID asserted: must be ignored.
        RESET = 1'b1;
        OUT_READY = 1'b1;
        apply(0);
        IN_VALID = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_out_valid dut%0d", k), 32'(out_valid[k]), 32'd0);
            chk($sformatf("reset_x dut%0d", k), 32'(x_o[k]), 32'd0);
            chk($sformatf("reset_ones dut%0d", k), 32'(ones_o[k]), 32'd0);
            chk($sformatf("reset_in_ready dut%0d", k), 32'(in_ready[k]), 32'd0);
        end
        RESET = 1'b0;
        IN_VALID = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) chk($sformatf("idle_in_ready dut%0d", k), 32'(in_ready[k]), 32'd1);

        // Single beat: OUT_VALID rises exactly STAGES-1 edges after the accepting edge.
        apply(0);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("latency dut%0d t%0d", k, t), 32'(out_valid[k]), 32'(t == sd(k) - 1));
            tick();
        end

        // Back-to-back MODE 0 then 1.
        send(0);
        send(1);
        IN_VALID = 1'b0;
        repeat (6) tick();

        // Backpressure: DUT0 fills after two beats, output holds, release restores ready at once.
        OUT_READY = 1'b0;
        apply(2);
        IN_VALID = 1'b1;
        tick();
        apply(3);
        tick();
        apply(4);
        chk("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
        @(negedge CLK);
        x_hold = x_o[0];
        ones_hold = ones_o[0];
        tick();
        @(negedge CLK);
        chk("bp_x_stable", 32'(x_o[0]), 32'(x_hold));
        chk("bp_ones_stable", 32'(ones_o[0]), 32'(ones_hold));
        chk("bp_out_valid_held", 32'(out_valid[0]), 32'd1);
        chk("bp_head_is_first", 32'(x_o[0]), 32'(tbl[2].x));
        tick();
        OUT_READY = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
        send(4);
        send(5);
        IN_VALID = 1'b0;
        repeat (8) tick();

        // Reset mid-flight: in-flight beats vanish.
        OUT_READY = 1'b0;
        send(6);
        send(7);
        RESET = 1'b1;
        tick();
        chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("midrst_x", 32'(x_o[0]), 32'd0);
        chk("midrst_ones", 32'(ones_o[0]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready[0]), 32'd0);
        RESET = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        repeat (8) tick();

        // Width boundary and assorted vectors, back to back.
        send(2);
        send(3);
        send(4);
        send(5);
        send(7);
        send(8);
        send(9);
        send(6);
        IN_VALID = 1'b0;
        repeat (8) tick();

        // Random valid/ready with the directed vectors.
        for (int i = 0; i < 400; i++) begin
            apply(int'($urandom_range(0, 9)));
            IN_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY = ($urandom_range(0, 2) != 0);
            tick();
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        repeat (12) tick();
        for (int k = 0; k < 3; k++)
            chk($sformatf("drain_empty dut%0d", k), 32'(sb_q[k].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
